mem_rd_arbiter: RTL and testbench
=================================

Name: mem_rd_arbiter

Overview:
Two-requester read-bus arbiter that lets the instruction fetch unit and the load path share one word-wide read bus. Each requester uses the c2c read protocol: re, addr, sel out; data, ack back. The arbiter grants one requester at a time and holds the grant until the downstream ack or a timeout. It arbitrates round-robin and supports back-to-back grants.

Parameters:
TIMEOUT, 64, cycles a granted transfer may wait for downstream ack before it is aborted (must be >=2)
DATA_PRIO, 1, on a simultaneous request from IDLE with no history, 1 grants the data port and 0 grants the instruction port

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
i_re  input  1  instruction-port read request
i_addr  input  32  instruction-port address (held stable while i_re is high and not acked)
i_sel  input  4  instruction-port byte select
i_data  output  32  instruction-port read data
i_ack  output  1  instruction-port transfer complete
d_re  input  1  data-port read request
d_addr  input  32  data-port address
d_sel  input  4  data-port byte select
d_data  output  32  data-port read data
d_ack  output  1  data-port transfer complete
m_re  output  1  downstream read enable
m_addr  output  32  downstream address
m_sel  output  4  downstream byte select
m_data  input  32  downstream read data
m_ack  input  1  downstream ack
err  output  1  one-cycle pulse on timeout abort
err_port  output  1  port that timed out (0=instr, 1=data), valid when err=1

Behaviour:
- State machine with registered states IDLE, GNT_I and GNT_D. A register last_d records the most recent owner (1=data) and sets the round-robin priority. A timeout counter tcnt is 16 bits, saturating.
- Reset (async, any time, including mid-transfer): state=IDLE, last_d=~DATA_PRIO, tcnt=0, err=0, err_port=0. In-flight transfers are dropped with no ack.
- Outputs in IDLE: m_re=0, m_addr=0, m_sel=0, i_ack=d_ack=0, i_data=d_data=0.
- Outputs in GNT_x: m_re=1, and m_addr/m_sel come combinationally from the owner's inputs. m_data goes to the owner's data output and is 0 to the other port. The owner's ack equals m_ack, combinationally in the same cycle. The other port's ack is 0.
- Arbitration runs in IDLE, and in GNT_x during the cycle m_ack=1:
  - If only one port requests, grant that port.
  - If both request, grant the port that is not last_d (round-robin). In the ack cycle, the requests sampled are the ones present in that cycle.
  - The winner becomes the next state at the next edge, and last_d updates to the winner.
  - If nobody requests, go to IDLE.
- Back-to-back: ack in cycle N with a request present means GNT_x is active in N+1, with no idle bubble. The minimum grant-to-ack latency is 1 cycle (m_ack may be high in the first GNT cycle).
- Request rules: a requester must hold re/addr/sel stable from assertion until its ack. If a requester drops re while granted and before ack, the arbiter still completes the transfer. The ack is delivered to that port anyway, and the port must ignore it.
- Timeout:
  - tcnt clears on entry to GNT_x and increments each GNT cycle without m_ack.
  - When tcnt reaches TIMEOUT-1 without ack, that cycle drives err=1 and err_port=owner, and gives no ack to the owner.
  - On the next edge the arbiter re-arbitrates as in an ack cycle and updates last_d, so the other port gets priority.
  - err is registered-free (combinational from state/tcnt) and lasts exactly one cycle.
- In GNT_x, a simultaneous m_ack and timeout cycle is treated as ack, not error.
- m_ack while in IDLE is ignored and produces no port ack.

Test Plan:
1. Reset, then i_re=1 with i_addr=0x100 only -> next cycle m_re=1, m_addr=0x100. With m_ack=1 and m_data=0xDEADBEEF: i_ack=1 and i_data=0xDEADBEEF in the same cycle, and d_ack=0.
2. i_re and d_re both raised in the same cycle from IDLE after reset with DATA_PRIO=1 -> GNT_D first. After the ack, GNT_I in the very next cycle, then alternating D,I,D,I while both keep requesting with 1-cycle acks.
3. d_re continuous with m_ack every cycle, i_re raised mid-stream -> the instruction port is granted in the cycle after the next data ack, so it is never starved beyond one transfer.
4. TIMEOUT=4, instruction granted, m_ack held 0 -> err=1 and err_port=0 in the 4th GNT cycle with i_ack=0. A pending d_re is granted the following cycle.
5. reset asserted for one cycle mid-GNT_D -> m_re=0 immediately (asynchronous), no d_ack. After release with i_re=1, a normal grant and ack complete.
6. m_ack pulsed in IDLE -> no i_ack/d_ack and no state change. A d_re dropped before ack -> the transfer still completes with d_ack=1, then IDLE.

Source files
------------

// File: rtl/mem_rd_arbiter_if.sv
// Read-bus bundle shared by the arbiter and its environment: the instruction
// and data requester ports, the downstream bus, and the timeout status.
interface mem_rd_arbiter_if;
    logic        i_re;
    logic [31:0] i_addr;
    logic [3:0]  i_sel;
    logic [31:0] i_data;
    logic        i_ack;

    logic        d_re;
    logic [31:0] d_addr;
    logic [3:0]  d_sel;
    logic [31:0] d_data;
    logic        d_ack;

    logic        m_re;
    logic [31:0] m_addr;
    logic [3:0]  m_sel;
    logic [31:0] m_data;
    logic        m_ack;

    logic        err;
    logic        err_port;

    // Arbiter side.
    modport slave (
        input  i_re, i_addr, i_sel, d_re, d_addr, d_sel, m_data, m_ack,
        output i_data, i_ack, d_data, d_ack, m_re, m_addr, m_sel, err, err_port
    );

    // Requesters plus downstream memory, as seen from outside the arbiter.
    modport master (
        output i_re, i_addr, i_sel, d_re, d_addr, d_sel, m_data, m_ack,
        input  i_data, i_ack, d_data, d_ack, m_re, m_addr, m_sel, err, err_port
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter letting the instruction and data ports share one read bus.
// A grant is held until the downstream ack, or aborted with an err pulse on timeout.
module mem_rd_arbiter #(
    parameter int unsigned TIMEOUT   = 64,
    parameter bit          DATA_PRIO = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    mem_rd_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] TCNT_MAX  = 16'hFFFF;

    state_e      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [15:0] tcnt_q, tcnt_d;

    logic granted;
    logic timeout;
    logic rearb;

    assign granted = (state_q == GNT_I) || (state_q == GNT_D);
    // An ack in the same cycle as the timeout wins: the transfer completed.
    assign timeout = granted && !bus.m_ack && (tcnt_q == TCNT_LAST);
    assign rearb   = !granted || bus.m_ack || timeout;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= ~DATA_PRIO;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        tcnt_d   = tcnt_q;

        if (granted && (tcnt_q != TCNT_MAX)) begin
            tcnt_d = tcnt_q + 16'd1;
        end

        if (rearb) begin
            tcnt_d = '0;
            if (bus.i_re && bus.d_re) begin
                state_d  = last_d_q ? GNT_I : GNT_D;
                last_d_d = ~last_d_q;
            end else if (bus.d_re) begin
                state_d  = GNT_D;
                last_d_d = 1'b1;
            end else if (bus.i_re) begin
                state_d  = GNT_I;
                last_d_d = 1'b0;
            end else begin
                state_d  = IDLE;
            end
        end
    end

    always_comb begin
        bus.m_re     = 1'b0;
        bus.m_addr   = '0;
        bus.m_sel    = '0;
        bus.i_data   = '0;
        bus.i_ack    = 1'b0;
        bus.d_data   = '0;
        bus.d_ack    = 1'b0;
        bus.err      = timeout;
        bus.err_port = timeout && (state_q == GNT_D);

        case (state_q)
            GNT_I: begin
                bus.m_re   = 1'b1;
                bus.m_addr = bus.i_addr;
                bus.m_sel  = bus.i_sel;
                bus.i_data = bus.m_data;
                bus.i_ack  = bus.m_ack;
            end
            GNT_D: begin
                bus.m_re   = 1'b1;
                bus.m_addr = bus.d_addr;
                bus.m_sel  = bus.d_sel;
                bus.d_data = bus.m_data;
                bus.d_ack  = bus.m_ack;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: a per-cycle vector table with an
// ack scoreboard, plus a hand-written asynchronous-reset sequence.
module tb_mem_rd_arbiter;

    logic clk;
    logic reset;

    mem_rd_arbiter_if bus();

    mem_rd_arbiter #(
        .TIMEOUT   (4),
        .DATA_PRIO (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // owner: 0 = idle (no grant), 1 = instruction port, 2 = data port
    typedef struct {
        logic        ire;
        logic [31:0] iaddr;
        logic        dre;
        logic [31:0] daddr;
        logic        mack;
        logic [31:0] mdata;
        logic        e_mre;
        logic [31:0] e_maddr;
        logic [3:0]  e_msel;
        logic        e_iack;
        logic [31:0] e_idata;
        logic        e_dack;
        logic [31:0] e_ddata;
        logic        e_err;
        logic        e_eport;
    } vec_t;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } sb_t;

    localparam int NV = 34;
    localparam logic [3:0] ISEL = 4'hF;
    localparam logic [3:0] DSEL = 4'h3;

    vec_t vecs[NV];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic ire, input logic [31:0] ia,
                                input logic dre, input logic [31:0] da,
                                input logic mack, input logic [31:0] md,
                                input int owner, input logic err, input logic eport);
        vec_t v;
        v.ire     = ire;
        v.iaddr   = ia;
        v.dre     = dre;
        v.daddr   = da;
        v.mack    = mack;
        v.mdata   = md;
        v.e_mre   = (owner != 0);
        v.e_maddr = (owner == 1) ? ia : (owner == 2) ? da : 32'h0;
        v.e_msel  = (owner == 1) ? ISEL : (owner == 2) ? DSEL : 4'h0;
        v.e_iack  = (owner == 1) && mack;
        v.e_idata = (owner == 1) ? md : 32'h0;
        v.e_dack  = (owner == 2) && mack;
        v.e_ddata = (owner == 2) ? md : 32'h0;
        v.e_err   = err;
        v.e_eport = eport;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic port, input logic [31:0] data);
        sb_t e;
        e.port = port;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Pop one expected completion for every ack the DUT shows this cycle.
    task automatic sb_observe(input string tag);
        sb_t e;
        if (bus.i_ack) begin
            if (sb_q.size() == 0) begin
                check({tag, " unexpected i_ack"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({tag, " sb port(i)"}, 32'(e.port), 32'd0);
                check({tag, " sb i_data"}, bus.i_data, e.data);
            end
        end
        if (bus.d_ack) begin
            if (sb_q.size() == 0) begin
                check({tag, " unexpected d_ack"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({tag, " sb port(d)"}, 32'(e.port), 32'd1);
                check({tag, " sb d_data"}, bus.d_data, e.data);
            end
        end
    endtask

    task automatic drive(input logic ire, input logic [31:0] ia, input logic dre,
                         input logic [31:0] da, input logic mack, input logic [31:0] md);
        bus.i_re   = ire;
        bus.i_addr = ia;
        bus.d_re   = dre;
        bus.d_addr = da;
        bus.m_ack  = mack;
        bus.m_data = md;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single request, same-cycle ack, then re drop before the second ack
        vecs[0]  = mk(0, 32'h000, 0, 32'h000, 0, 32'h0,        0, 0, 0);
        vecs[1]  = mk(1, 32'h100, 0, 32'h000, 0, 32'h0,        0, 0, 0);
        vecs[2]  = mk(1, 32'h100, 0, 32'h000, 1, 32'hDEADBEEF, 1, 0, 0);
        vecs[3]  = mk(0, 32'h100, 0, 32'h000, 1, 32'h11111111, 1, 0, 0);
        vecs[4]  = mk(0, 32'h000, 0, 32'h000, 1, 32'hCAFE0000, 0, 0, 0);
        // Simultaneous requests: data first, then strict alternation
        vecs[5]  = mk(1, 32'h200, 1, 32'h300, 0, 32'h0,        0, 0, 0);
        vecs[6]  = mk(1, 32'h200, 1, 32'h300, 1, 32'hD0000001, 2, 0, 0);
        vecs[7]  = mk(1, 32'h200, 1, 32'h300, 1, 32'hA0000001, 1, 0, 0);
        vecs[8]  = mk(1, 32'h200, 1, 32'h300, 1, 32'hD0000002, 2, 0, 0);
        vecs[9]  = mk(1, 32'h200, 1, 32'h300, 1, 32'hA0000002, 1, 0, 0);
        // Data streaming, instruction joins mid-stream
        vecs[10] = mk(0, 32'h200, 1, 32'h300, 1, 32'hD0000003, 2, 0, 0);
        vecs[11] = mk(1, 32'h240, 1, 32'h300, 1, 32'hD0000004, 2, 0, 0);
        vecs[12] = mk(1, 32'h240, 1, 32'h300, 1, 32'hA0000003, 1, 0, 0);
        vecs[13] = mk(0, 32'h240, 1, 32'h300, 1, 32'hD0000005, 2, 0, 0);
        // Instruction grant times out in its 4th cycle; pending data wins next
        vecs[14] = mk(1, 32'h400, 0, 32'h300, 1, 32'hD0000006, 2, 0, 0);
        vecs[15] = mk(1, 32'h400, 1, 32'h500, 0, 32'h0,        1, 0, 0);
        vecs[16] = mk(1, 32'h400, 1, 32'h500, 0, 32'h0,        1, 0, 0);
        vecs[17] = mk(1, 32'h400, 1, 32'h500, 0, 32'h0,        1, 0, 0);
        vecs[18] = mk(1, 32'h400, 1, 32'h500, 0, 32'h0,        1, 1, 0);
        vecs[19] = mk(0, 32'h400, 1, 32'h500, 1, 32'hD0000007, 2, 0, 0);
        // Data drops re while granted; transfer still completes
        vecs[20] = mk(0, 32'h000, 0, 32'h500, 0, 32'h0,        2, 0, 0);
        vecs[21] = mk(0, 32'h000, 0, 32'h500, 1, 32'hD0000008, 2, 0, 0);
        vecs[22] = mk(0, 32'h000, 0, 32'h000, 0, 32'h0,        0, 0, 0);
        // Ack coinciding with timeout counts as ack; later a data timeout
        vecs[23] = mk(0, 32'h000, 1, 32'h600, 0, 32'h0,        0, 0, 0);
        vecs[24] = mk(0, 32'h000, 1, 32'h600, 0, 32'h0,        2, 0, 0);
        vecs[25] = mk(0, 32'h000, 1, 32'h600, 0, 32'h0,        2, 0, 0);
        vecs[26] = mk(0, 32'h000, 1, 32'h600, 0, 32'h0,        2, 0, 0);
        vecs[27] = mk(0, 32'h000, 1, 32'h600, 1, 32'hD0000009, 2, 0, 0);
        vecs[28] = mk(0, 32'h000, 1, 32'h600, 0, 32'h0,        2, 0, 0);
        vecs[29] = mk(0, 32'h000, 1, 32'h600, 0, 32'h0,        2, 0, 0);
        vecs[30] = mk(0, 32'h000, 1, 32'h600, 0, 32'h0,        2, 0, 0);
        vecs[31] = mk(0, 32'h000, 1, 32'h600, 0, 32'h0,        2, 1, 1);
        vecs[32] = mk(0, 32'h000, 0, 32'h600, 1, 32'hD000000A, 2, 0, 0);
        vecs[33] = mk(0, 32'h000, 0, 32'h000, 0, 32'h0,        0, 0, 0);

        reset     = 1'b1;
        bus.i_sel = ISEL;
        bus.d_sel = DSEL;
        drive(0, 32'h0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset m_re", 32'(bus.m_re), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset err_port", 32'(bus.err_port), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            string t;
            @(posedge clk);
            #1;
            drive(vecs[i].ire, vecs[i].iaddr, vecs[i].dre, vecs[i].daddr,
                  vecs[i].mack, vecs[i].mdata);
            if (vecs[i].e_iack) sb_push(1'b0, vecs[i].mdata);
            if (vecs[i].e_dack) sb_push(1'b1, vecs[i].mdata);
            #3;
            t = $sformatf("v%0d", i);
            check({t, " m_re"},     32'(bus.m_re),     32'(vecs[i].e_mre));
            check({t, " m_addr"},   bus.m_addr,        vecs[i].e_maddr);
            check({t, " m_sel"},    32'(bus.m_sel),    32'(vecs[i].e_msel));
            check({t, " i_ack"},    32'(bus.i_ack),    32'(vecs[i].e_iack));
            check({t, " i_data"},   bus.i_data,        vecs[i].e_idata);
            check({t, " d_ack"},    32'(bus.d_ack),    32'(vecs[i].e_dack));
            check({t, " d_data"},   bus.d_data,        vecs[i].e_ddata);
            check({t, " err"},      32'(bus.err),      32'(vecs[i].e_err));
            check({t, " err_port"}, 32'(bus.err_port), 32'(vecs[i].e_eport));
            sb_observe(t);
        end

        // Asynchronous reset in the middle of a data grant
        @(posedge clk);
        #1;
        drive(0, 32'h0, 1, 32'h700, 0, 32'h0);
        #3;
        check("ar idle m_re", 32'(bus.m_re), 32'd0);
        @(posedge clk);
        #1;
        check("ar gnt_d m_re", 32'(bus.m_re), 32'd1);
        check("ar gnt_d m_addr", bus.m_addr, 32'h700);
        bus.m_ack  = 1'b1;
        bus.m_data = 32'h00000077;
        #1;
        reset = 1'b1;
        #1;
        check("ar in-reset m_re", 32'(bus.m_re), 32'd0);
        check("ar in-reset d_ack", 32'(bus.d_ack), 32'd0);
        check("ar in-reset d_data", bus.d_data, 32'h0);
        sb_observe("ar in-reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1, 32'h800, 0, 32'h0, 0, 32'h0);
        #3;
        check("ar post idle m_re", 32'(bus.m_re), 32'd0);
        @(posedge clk);
        #1;
        drive(1, 32'h800, 0, 32'h0, 1, 32'h55AA55AA);
        sb_push(1'b0, 32'h55AA55AA);
        #3;
        check("ar gnt_i m_re", 32'(bus.m_re), 32'd1);
        check("ar gnt_i m_addr", bus.m_addr, 32'h800);
        check("ar gnt_i i_ack", 32'(bus.i_ack), 32'd1);
        check("ar gnt_i d_ack", 32'(bus.d_ack), 32'd0);
        sb_observe("ar gnt_i");
        @(posedge clk);
        #1;
        drive(0, 32'h800, 0, 32'h0, 1, 32'h12345678);
        sb_push(1'b0, 32'h12345678);
        #3;
        check("ar regrant i_ack", 32'(bus.i_ack), 32'd1);
        sb_observe("ar regrant");
        @(posedge clk);
        #1;
        drive(0, 32'h0, 0, 32'h0, 0, 32'h0);
        #3;
        check("ar final m_re", 32'(bus.m_re), 32'd0);

        check("sb drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
